cv32e40x_clmul_seq: RTL and testbench



---
 rtl/cv32e40x_clmul_seq.sv | 145 ++++++++++++++
 tb/tb_cv32e40x_clmul_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40x_clmul_seq.sv
// Sequential carry-less multiplier for the Zbc ops (clmul/clmulh/clmulr).
// Consumes BITS_PER_CYCLE bits of operand B per cycle; the latency does not depend on the data.
module cv32e40x_clmul_seq #(
  parameter int unsigned BITS_PER_CYCLE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [1:0]  op_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic        kill_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o
);

  localparam int unsigned NUM_CYC = 32 / BITS_PER_CYCLE;
  localparam int unsigned CNT_W   = (NUM_CYC > 1) ? $clog2(NUM_CYC) : 1;

  if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4 ||
        BITS_PER_CYCLE == 8 || BITS_PER_CYCLE == 16 || BITS_PER_CYCLE == 32)) begin : g_bad_bpc
    $error("BITS_PER_CYCLE must be one of 1, 2, 4, 8, 16, 32");
  end

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    BUSY = 3'b010,
    DONE = 3'b100
  } state_e;

  state_e             state_q, state_d;
  logic [62:0]        acc_q, acc_d, acc_step;
  logic [62:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [1:0]         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        result_q, result_d, res_sel;
  logic               accept;
  logic               last_busy;

  assign accept    = (state_q == IDLE) && valid_i && !kill_i;
  assign last_busy = (state_q == BUSY) && (cnt_q == CNT_W'(NUM_CYC - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; kill overrides every transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_i) state_d = BUSY;
      BUSY:    if (last_busy) state_d = DONE;
      DONE:    if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill_i) begin
      state_d = IDLE;
    end
  end

  // Output logic
  always_comb begin
    ready_o  = (state_q == IDLE);
    valid_o  = (state_q == DONE);
    result_o = result_q;
  end

  // One iteration: fold BITS_PER_CYCLE partial products into the accumulator
  always_comb begin
    acc_step = acc_q;
    for (int unsigned j = 0; j < BITS_PER_CYCLE; j++) begin
      if (b_q[j]) begin
        acc_step = acc_step ^ (a_q << j);
      end
    end
  end

  // The slice is taken from acc_step so the result register loads on the final BUSY edge
  always_comb begin
    case (op_q)
      2'b01:   res_sel = {1'b0, acc_step[62:32]};
      2'b10:   res_sel = acc_step[62:31];
      default: res_sel = acc_step[31:0];
    endcase
  end

  always_comb begin
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (accept) begin
      op_d  = op_i;
      a_d   = {31'd0, op_a_i};
      b_d   = op_b_i;
      acc_d = '0;
      cnt_d = '0;
    end else if (state_q == BUSY && !kill_i) begin
      acc_d = acc_step;
      a_d   = a_q << BITS_PER_CYCLE;
      b_d   = b_q >> BITS_PER_CYCLE;
      cnt_d = cnt_q + CNT_W'(1);
      if (last_busy) begin
        result_d = res_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  a_onehot_state: assert property (@(posedge clk) disable iff (!rst_n) $onehot(state_q));
  a_result_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (valid_o && !ready_i && !kill_i) |=> $stable(result_o));
  a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == BUSY) |-> (cnt_q <= CNT_W'(NUM_CYC - 1)));
  a_valid_ready_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(valid_o && ready_o));

endmodule

// File: tb/tb_cv32e40x_clmul_seq.sv
// Bench for cv32e40x_clmul_seq: runs the same test flow on four instances (BITS_PER_CYCLE 4, 1, 8, 32).
// Each instance is compared against a transaction-level model.
module tb_cv32e40x_clmul_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  function automatic int unsigned bpc_of(input int unsigned i);
    case (i)
      0:       return 4;
      1:       return 1;
      2:       return 8;
      default: return 32;
    endcase
  endfunction

  // Reference: the full 64-bit carry-less product, then the op's slice
  function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) p = p ^ ({32'd0, a} << i);
    end
    case (op)
      2'b01:   return p[63:32];
      2'b10:   return p[62:31];
      default: return p[31:0];
    endcase
  endfunction

  task automatic chk(input string name, input int unsigned bpc, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s bpc=%0d got=%0h exp=%0h at %0t", name, bpc, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_inst
    localparam int unsigned BPC = bpc_of(g);
    localparam int unsigned NUM = 32 / BPC;

    logic        rst_n, valid_i, ready_o, kill_i, valid_o, ready_i;
    logic [1:0]  op_i;
    logic [31:0] op_a_i, op_b_i, result_o;
    bit          done_f = 1'b0;

    cv32e40x_clmul_seq #(.BITS_PER_CYCLE(BPC)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .op_i     (op_i),
      .op_a_i   (op_a_i),
      .op_b_i   (op_b_i),
      .kill_i   (kill_i),
      .valid_o  (valid_o),
      .ready_i  (ready_i),
      .result_o (result_o)
    );

    // Transaction model: idle / counting down NUM cycles / holding a result
    bit          m_idle  = 1'b1;
    bit          m_done  = 1'b0;
    bit          m_known = 1'b1;
    int          m_left  = 0;
    logic [31:0] m_pend  = '0;
    logic [31:0] m_res   = '0;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_idle = 1'b1; m_done = 1'b0; m_known = 1'b1; m_res = '0; m_left = 0;
      end else if (kill_i) begin
        m_idle = 1'b1; m_done = 1'b0; m_known = 1'b0;
      end else if (m_idle) begin
        if (valid_i) begin
          m_idle = 1'b0; m_left = NUM; m_known = 1'b0;
          m_pend = ref_op(op_i, op_a_i, op_b_i);
        end
      end else if (!m_done) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1; m_res = m_pend; m_known = 1'b1;
        end
      end else if (ready_i) begin
        m_done = 1'b0; m_idle = 1'b1;
      end
    end

    always @(negedge clk) begin
      chk("mon_ready_o", BPC, {31'd0, ready_o}, {31'd0, m_idle});
      chk("mon_valid_o", BPC, {31'd0, valid_o}, {31'd0, m_done});
      if (m_known) chk("mon_result_o", BPC, result_o, m_res);
    end

    task automatic step();
      @(posedge clk);
      #1;
    endtask

    task automatic accept(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      chk("accept_ready_before", BPC, {31'd0, ready_o}, 32'd1);
      valid_i = 1'b1; op_i = op; op_a_i = a; op_b_i = b;
      step();
      valid_i = 1'b0;
      op_i = 2'($urandom); op_a_i = $urandom; op_b_i = $urandom;
      chk("accept_busy_after", BPC, {31'd0, ready_o}, 32'd0);
    endtask

    task automatic await_valid();
      int lat;
      lat = 0;
      while (valid_o !== 1'b1 && lat < 200) begin
        step();
        lat++;
      end
      chk("latency", BPC, lat, NUM);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int unsigned stall);
      accept(op, a, b);
      await_valid();
      chk("result", BPC, result_o, exp);
      for (int unsigned s = 0; s < stall; s++) begin
        step();
        chk("stall_valid", BPC, {31'd0, valid_o}, 32'd1);
        chk("stall_ready", BPC, {31'd0, ready_o}, 32'd0);
        chk("stall_result", BPC, result_o, exp);
      end
      ready_i = 1'b1;
      step();
      ready_i = 1'b0;
      chk("release_valid", BPC, {31'd0, valid_o}, 32'd0);
      chk("release_ready", BPC, {31'd0, ready_o}, 32'd1);
    endtask

    initial begin
      int unsigned kc;
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      rst_n = 1'b0; valid_i = 1'b0; kill_i = 1'b0; ready_i = 1'b0;
      op_i = '0; op_a_i = '0; op_b_i = '0;
      #22;
      chk("rst_ready", BPC, {31'd0, ready_o}, 32'd1);
      chk("rst_valid", BPC, {31'd0, valid_o}, 32'd0);
      chk("rst_result", BPC, result_o, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      step();

      run_op(2'b00, 32'h3, 32'h3, 32'h5, 0);
      run_op(2'b00, 32'h8000_0000, 32'h2, 32'h0, 0);
      run_op(2'b01, 32'h8000_0000, 32'h2, 32'h1, 0);
      run_op(2'b10, 32'h8000_0000, 32'h2, 32'h2, 0);
      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555, 0);
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555, 0);
      run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 5);
      run_op(2'b11, 32'h3, 32'h3, 32'h5, 0);

      // Kill mid-BUSY (3rd BUSY cycle where one exists)
      kc = (NUM >= 3) ? 3 : 1;
      accept(2'b00, $urandom, $urandom);
      repeat (kc - 1) step();
      kill_i = 1'b1;
      step();
      kill_i = 1'b0;
      chk("kill_busy_ready", BPC, {31'd0, ready_o}, 32'd1);
      for (int unsigned i = 0; i < NUM + 3; i++) begin
        step();
        chk("kill_busy_novalid", BPC, {31'd0, valid_o}, 32'd0);
      end

      // Kill together with a request in IDLE
      valid_i = 1'b1; kill_i = 1'b1; op_i = 2'b00; op_a_i = 32'h3; op_b_i = 32'h3;
      step();
      valid_i = 1'b0; kill_i = 1'b0;
      chk("kill_idle_noaccept", BPC, {31'd0, ready_o}, 32'd1);
      for (int unsigned i = 0; i < NUM + 2; i++) begin
        step();
        chk("kill_idle_novalid", BPC, {31'd0, valid_o}, 32'd0);
      end

      // Kill together with ready_i in DONE
      accept(2'b00, 32'h3, 32'h3);
      await_valid();
      chk("kill_done_result", BPC, result_o, 32'h5);
      ready_i = 1'b1; kill_i = 1'b1;
      step();
      ready_i = 1'b0; kill_i = 1'b0;
      chk("kill_done_valid", BPC, {31'd0, valid_o}, 32'd0);
      chk("kill_done_ready", BPC, {31'd0, ready_o}, 32'd1);

      // Asynchronous reset mid-BUSY
      run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 0);
      accept(2'b00, 32'h3, 32'h3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_ready", BPC, {31'd0, ready_o}, 32'd1);
      chk("arst_valid", BPC, {31'd0, valid_o}, 32'd0);
      chk("arst_result", BPC, result_o, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      step();
      run_op(2'b00, 32'h3, 32'h3, 32'h5, 0);

      for (int unsigned n = 0; n < 40; n++) begin
        rop = 2'($urandom_range(0, 3));
        ra  = $urandom;
        rb  = $urandom;
        run_op(rop, ra, rb, ref_op(rop, ra, rb), $urandom_range(0, 3));
      end
      done_f = 1'b1;
    end
  end

  initial begin
    int unsigned c;
    c = 0;
    while (!(g_inst[0].done_f && g_inst[1].done_f && g_inst[2].done_f && g_inst[3].done_f) && c < 80000) begin
      @(posedge clk);
      c++;
    end
    n_vec++;
    if (!(g_inst[0].done_f && g_inst[1].done_f && g_inst[2].done_f && g_inst[3].done_f)) begin
      n_err++;
      $display("FAIL timeout got=%0d cycles exp=completion", c);
    end
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
